// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for the interrupt/ERET flush initiator.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    FLUSH    = 2'd2,
    REDIRECT = 2'd3
  } flush_state_t;

  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
  localparam int unsigned DRAIN_MAX_DEF    = 64;
  localparam logic [31:0] EPC_DS_OFFSET    = 32'd4;

  // A delay-slot instruction restarts from its branch so the branch re-executes.
  function automatic logic [31:0] epcValue(input logic [31:0] pc, input logic bd);
    return bd ? (pc - EPC_DS_OFFSET) : pc;
  endfunction

endpackage

// File: rtl/drain_watchdog.sv
// Counts cycles spent draining mult/div; raises a sticky flag at DRAIN_MAX.
module drain_watchdog #(
  parameter int unsigned DRAIN_MAX = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic timeout
);

  localparam int unsigned CW = $clog2(DRAIN_MAX + 1);

  logic [CW-1:0] count;

  // Counter saturates at DRAIN_MAX so a long drain never wraps the compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      timeout <= 1'b0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count != CW'(DRAIN_MAX)) count <= count + CW'(1);
      if (count == CW'(DRAIN_MAX - 1)) timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/interrupt_flush_controller.sv
// Decides when to take an interrupt or ERET, flushes the pipeline carriers,
// captures EPC and redirects fetch; stalls everything while mult/div drains.
module interrupt_flush_controller
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
  parameter int unsigned DRAIN_MAX    = DRAIN_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IntPending,
  input  logic        ValidM,
  input  logic [31:0] PCM,
  input  logic        BranchDelayM,
  input  logic        EretM,
  input  logic        MDBusy,
  input  logic [31:0] EPCIn,
  output logic        InterruptRequest,
  output logic        StallAll,
  output logic        PCRedirect,
  output logic [31:0] PCTarget,
  output logic        EPCWrite,
  output logic [31:0] EPCOut,
  output logic        BDOut,
  output logic        EXLClear,
  output logic        DrainTimeout,
  output logic [1:0]  StateOut
);

  flush_state_t state, nextState;
  logic [31:0]  targetReg, targetNext;
  logic         drainEn, drainClr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      targetReg <= '0;
    end else begin
      state     <= nextState;
      targetReg <= targetNext;
    end
  end

  always_comb begin
    nextState        = state;
    targetNext       = targetReg;
    drainEn          = 1'b0;
    drainClr         = 1'b0;
    InterruptRequest = 1'b0;
    StallAll         = 1'b0;
    PCRedirect       = 1'b0;
    PCTarget         = '0;
    EPCWrite         = 1'b0;
    EXLClear         = 1'b0;

    case (state)
      IDLE: begin
        // Interrupt wins over a simultaneous ERET; bubbles never take either.
        if (IntPending && ValidM) begin
          if (!MDBusy) begin
            InterruptRequest = 1'b1;
            EPCWrite         = 1'b1;
            targetNext       = HANDLER_ADDR;
            nextState        = REDIRECT;
          end else begin
            nextState = DRAIN;
          end
        end else if (EretM && ValidM) begin
          InterruptRequest = 1'b1;
          EXLClear         = 1'b1;
          targetNext       = EPCIn;
          nextState        = REDIRECT;
        end
      end
      DRAIN: begin
        StallAll = 1'b1;
        drainEn  = 1'b1;
        if (!MDBusy) nextState = FLUSH;
      end
      FLUSH: begin
        InterruptRequest = 1'b1;
        EPCWrite         = 1'b1;
        targetNext       = HANDLER_ADDR;
        drainClr         = 1'b1;
        nextState        = REDIRECT;
      end
      REDIRECT: begin
        PCRedirect = 1'b1;
        PCTarget   = targetReg;
        nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase

    // Mealy outputs would otherwise follow live inputs while reset is held.
    if (!reset) begin
      InterruptRequest = 1'b0;
      StallAll         = 1'b0;
      PCRedirect       = 1'b0;
      PCTarget         = '0;
      EPCWrite         = 1'b0;
      EXLClear         = 1'b0;
    end
  end

  assign EPCOut   = EPCWrite ? epcValue(PCM, BranchDelayM) : '0;
  assign BDOut    = EPCWrite & BranchDelayM;
  assign StateOut = state;

  drain_watchdog #(
    .DRAIN_MAX(DRAIN_MAX)
  ) uWatchdog (
    .clk    (clk),
    .reset  (reset),
    .en     (drainEn),
    .clr    (drainClr),
    .timeout(DrainTimeout)
  );

endmodule

// File: tb/tb_interrupt_flush_controller.sv
// Self-checking bench: directed scenarios plus randomized transactions whose
// expected cycle-by-cycle outputs are generated from the protocol rules.
module tb_interrupt_flush_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        IntPending, ValidM, BranchDelayM, EretM, MDBusy;
  logic [31:0] PCM, EPCIn;
  logic        InterruptRequest, StallAll, PCRedirect, EPCWrite, BDOut, EXLClear, DrainTimeout;
  logic [31:0] PCTarget, EPCOut;
  logic [1:0]  StateOut;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] HANDLER = 32'h0000_4180;

  typedef struct packed {
    logic [1:0]  st;
    logic        ir, stall, redir;
    logic [31:0] tgt;
    logic        epcw;
    logic [31:0] epc;
    logic        bd, exlc, dto;
  } exp_t;

  typedef struct packed {
    logic        ip, vm;
    logic [31:0] pc;
    logic        bd, er, md;
    logic [31:0] epcin;
  } in_t;

  interrupt_flush_controller dut (
    .clk(clk), .reset(reset), .IntPending(IntPending), .ValidM(ValidM), .PCM(PCM),
    .BranchDelayM(BranchDelayM), .EretM(EretM), .MDBusy(MDBusy), .EPCIn(EPCIn),
    .InterruptRequest(InterruptRequest), .StallAll(StallAll), .PCRedirect(PCRedirect),
    .PCTarget(PCTarget), .EPCWrite(EPCWrite), .EPCOut(EPCOut), .BDOut(BDOut),
    .EXLClear(EXLClear), .DrainTimeout(DrainTimeout), .StateOut(StateOut)
  );

  always #5 clk = ~clk;

  function automatic exp_t snap();
    exp_t s;
    s.st = StateOut; s.ir = InterruptRequest; s.stall = StallAll; s.redir = PCRedirect;
    s.tgt = PCTarget; s.epcw = EPCWrite; s.epc = EPCOut; s.bd = BDOut;
    s.exlc = EXLClear; s.dto = DrainTimeout;
    return s;
  endfunction

  function automatic in_t randIn();
    in_t v;
    v.ip = 1'($urandom); v.vm = 1'($urandom); v.pc = $urandom; v.bd = 1'($urandom);
    v.er = 1'($urandom); v.md = 1'($urandom); v.epcin = $urandom;
    return v;
  endfunction

  task automatic apply(input in_t v);
    IntPending = v.ip; ValidM = v.vm; PCM = v.pc; BranchDelayM = v.bd;
    EretM = v.er; MDBusy = v.md; EPCIn = v.epcin;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e = '0;
    reset = 1'b0;
    apply('{ip:1'b1, vm:1'b1, pc:32'h3010, bd:1'b0, er:1'b0, md:1'b0, epcin:32'h0});
    #12;
    checks++;
    if (snap() !== e) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", snap(), e);
    end
    apply('0);
    @(negedge clk) reset = 1'b1;
    tick();
  endtask

  task automatic test_plain(input logic [31:0] pc, input logic bd, input logic [31:0] epc);
    exp_t e;
    apply('{ip:1'b1, vm:1'b1, pc:pc, bd:bd, er:1'b0, md:1'b0, epcin:32'h0});
    @(negedge clk);
    e = '0; e.ir = 1'b1; e.epcw = 1'b1; e.epc = epc; e.bd = bd;
    checks++;
    if (snap() !== e) begin
      failures++; $display("FAIL plain_flush pc=%h got=%h exp=%h", pc, snap(), e);
    end
    tick(); apply('0);
    @(negedge clk);
    e = '0; e.st = 2'd3; e.redir = 1'b1; e.tgt = HANDLER;
    checks++;
    if (snap() !== e) begin
      failures++; $display("FAIL plain_redirect got=%h exp=%h", snap(), e);
    end
    tick();
    @(negedge clk);
    e = '0;
    checks++;
    if (snap() !== e) begin
      failures++; $display("FAIL plain_idle got=%h exp=%h", snap(), e);
    end
    tick();
  endtask

  task automatic test_drain();
    exp_t e;
    apply('{ip:1'b1, vm:1'b1, pc:32'h3100, bd:1'b0, er:1'b0, md:1'b1, epcin:32'h0});
    @(negedge clk);
    e = '0;
    checks++;
    if (snap() !== e) begin
      failures++; $display("FAIL drain_detect got=%h exp=%h", snap(), e);
    end
    tick();
    for (int k = 1; k <= 5; k++) begin
      MDBusy = (k < 5);
      IntPending = (k != 2);
      @(negedge clk);
      e = '0; e.st = 2'd1; e.stall = 1'b1;
      checks++;
      if (snap() !== e) begin
        failures++; $display("FAIL drain_stall k=%0d got=%h exp=%h", k, snap(), e);
      end
      tick();
    end
    MDBusy = 1'b0;
    @(negedge clk);
    e = '0; e.st = 2'd2; e.ir = 1'b1; e.epcw = 1'b1; e.epc = 32'h3100;
    checks++;
    if (snap() !== e) begin
      failures++; $display("FAIL drain_flush got=%h exp=%h", snap(), e);
    end
    tick(); apply('0);
    @(negedge clk);
    e = '0; e.st = 2'd3; e.redir = 1'b1; e.tgt = HANDLER;
    checks++;
    if (snap() !== e) begin
      failures++; $display("FAIL drain_redirect got=%h exp=%h", snap(), e);
    end
    tick();
  endtask

  task automatic test_eret();
    exp_t e;
    apply('{ip:1'b0, vm:1'b1, pc:32'h0, bd:1'b0, er:1'b1, md:1'b0, epcin:32'h3014});
    @(negedge clk);
    e = '0; e.ir = 1'b1; e.exlc = 1'b1;
    checks++;
    if (snap() !== e) begin
      failures++; $display("FAIL eret_flush got=%h exp=%h", snap(), e);
    end
    tick(); apply('0);
    @(negedge clk);
    e = '0; e.st = 2'd3; e.redir = 1'b1; e.tgt = 32'h3014;
    checks++;
    if (snap() !== e) begin
      failures++; $display("FAIL eret_redirect got=%h exp=%h", snap(), e);
    end
    tick();
  endtask

  task automatic test_bubble_priority();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      apply('{ip:1'b1, vm:1'b0, pc:32'h3200, bd:1'b0, er:1'b1, md:1'b0, epcin:32'h5555});
      @(negedge clk);
      e = '0;
      checks++;
      if (snap() !== e) begin
        failures++; $display("FAIL bubble k=%0d got=%h exp=%h", k, snap(), e);
      end
      tick();
    end
    ValidM = 1'b1;
    @(negedge clk);
    e = '0; e.ir = 1'b1; e.epcw = 1'b1; e.epc = 32'h3200;
    checks++;
    if (snap() !== e) begin
      failures++; $display("FAIL priority_flush got=%h exp=%h", snap(), e);
    end
    tick(); apply('0);
    @(negedge clk);
    e = '0; e.st = 2'd3; e.redir = 1'b1; e.tgt = HANDLER;
    checks++;
    if (snap() !== e) begin
      failures++; $display("FAIL priority_redirect got=%h exp=%h", snap(), e);
    end
    tick();
  endtask

  task automatic test_random(input int unsigned nTxn);
    in_t  inQ[$];
    exp_t expQ[$];
    for (int unsigned t = 0; t < nTxn; t++) begin
      in_t vi; exp_t ve; int unsigned kind, n;
      logic [31:0] pc, epc, tgt; logic bd;
      inQ.delete(); expQ.delete();
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        vi = randIn();
        if (vi.vm) begin vi.ip = 1'b0; vi.er = 1'b0; end
        inQ.push_back(vi); expQ.push_back('0);
      end else if (kind == 2) begin
        tgt = $urandom;
        vi = randIn(); vi.ip = 1'b0; vi.vm = 1'b1; vi.er = 1'b1; vi.epcin = tgt;
        ve = '0; ve.ir = 1'b1; ve.exlc = 1'b1;
        inQ.push_back(vi); expQ.push_back(ve);
        ve = '0; ve.st = 2'd3; ve.redir = 1'b1; ve.tgt = tgt;
        inQ.push_back(randIn()); expQ.push_back(ve);
      end else begin
        n   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6);
        pc  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        bd  = 1'($urandom);
        epc = bd ? pc - 32'd4 : pc;
        vi = randIn(); vi.ip = 1'b1; vi.vm = 1'b1; vi.pc = pc; vi.bd = bd;
        vi.er = (kind == 3); vi.md = (n > 0);
        ve = '0;
        if (n == 0) begin ve.ir = 1'b1; ve.epcw = 1'b1; ve.epc = epc; ve.bd = bd; end
        inQ.push_back(vi); expQ.push_back(ve);
        for (int unsigned k = 1; k <= n; k++) begin
          vi = randIn(); vi.vm = 1'b1; vi.pc = pc; vi.bd = bd; vi.md = (k < n);
          ve = '0; ve.st = 2'd1; ve.stall = 1'b1;
          inQ.push_back(vi); expQ.push_back(ve);
        end
        if (n > 0) begin
          vi = randIn(); vi.vm = 1'b1; vi.pc = pc; vi.bd = bd;
          ve = '0; ve.st = 2'd2; ve.ir = 1'b1; ve.epcw = 1'b1; ve.epc = epc; ve.bd = bd;
          inQ.push_back(vi); expQ.push_back(ve);
        end
        ve = '0; ve.st = 2'd3; ve.redir = 1'b1; ve.tgt = HANDLER;
        inQ.push_back(randIn()); expQ.push_back(ve);
      end
      while (inQ.size() > 0) begin
        vi = inQ.pop_front();
        ve = expQ.pop_front();
        apply(vi);
        @(negedge clk);
        checks++;
        if (snap() !== ve) begin
          failures++;
          $display("FAIL random txn=%0d kind=%0d got=%h exp=%h", t, kind, snap(), ve);
        end
        tick();
      end
    end
    apply('0);
  endtask

  task automatic test_timeout_reset();
    exp_t e;
    apply('{ip:1'b1, vm:1'b1, pc:32'h3300, bd:1'b0, er:1'b0, md:1'b1, epcin:32'h0});
    tick();
    for (int k = 1; k <= 70; k++) begin
      IntPending = 1'($urandom);
      @(negedge clk);
      e = '0; e.st = 2'd1; e.stall = 1'b1; e.dto = (k > 64);
      checks++;
      if (snap() !== e) begin
        failures++; $display("FAIL timeout_drain k=%0d got=%h exp=%h", k, snap(), e);
      end
      tick();
    end
    IntPending = 1'b1;
    #2 reset = 1'b0;
    #1;
    e = '0;
    checks++;
    if (snap() !== e) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", snap(), e);
    end
    apply('0);
    @(negedge clk) reset = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (snap() !== e) begin
        failures++; $display("FAIL post_reset k=%0d got=%h exp=%h", k, snap(), e);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_plain(32'h3010, 1'b0, 32'h3010);
    test_plain(32'h3024, 1'b1, 32'h3020);
    test_drain();
    test_eret();
    test_bubble_priority();
    test_random(150);
    test_timeout_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_flush_controller.md
Name: interrupt_flush_controller

Overview:
- Initiator side of the pipeline flush interface. Decides when to take an interrupt or an ERET.
- Generates the InterruptRequest flush that every pipeline carrier (F/D, D/E, E/M, M/W) obeys.
- Captures EPC and redirects fetch.
- Sits beside CP0 and the hazard unit. Stalls the whole pipeline while the mult/div unit drains.

Parameters:
- HANDLER_ADDR, 32'h0000_4180: exception vector loaded into PC on interrupt.
- DRAIN_MAX, 64: maximum cycles spent in DRAIN before DrainTimeout is flagged.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- IntPending  in  1  from CP0: (IP & IM) != 0 && IE && !EXL
- ValidM  in  1  M stage holds a real instruction (not a bubble)
- PCM  in  32  PC of the instruction in M
- BranchDelayM  in  1  instruction in M is in a branch delay slot
- EretM  in  1  instruction in M is ERET
- MDBusy  in  1  mult/div unit busy
- EPCIn  in  32  current CP0 EPC value (ERET target)
- InterruptRequest  out  1  flush to all four carriers
- StallAll  out  1  freeze PC and all carriers (F/D..M/W hold)
- PCRedirect  out  1  load PCTarget into PC this cycle
- PCTarget  out  32  redirect address
- EPCWrite  out  1  CP0 writes EPCOut/BDOut, sets EXL
- EPCOut  out  32  value written to EPC
- BDOut  out  1  Cause.BD value
- EXLClear  out  1  CP0 clears EXL (ERET)
- DrainTimeout  out  1  sticky watchdog flag
- StateOut  out  2  current FSM state, debug only

Behaviour:
- Reset (reset==0, async): state=IDLE, drain counter=0, target register=0, DrainTimeout=0, all outputs 0.
- States: IDLE=0, DRAIN=1, FLUSH=2, REDIRECT=3.
- IDLE, interrupt taken: requires IntPending && ValidM.
  - MDBusy==0: same cycle (Mealy) assert InterruptRequest=1, EPCWrite=1. Latch target=HANDLER_ADDR. Next state is REDIRECT.
  - MDBusy==1: next state is DRAIN. StallAll is asserted from the next cycle.
- IDLE, IntPending && !ValidM: no action. Wait for a valid M instruction; a bubble never yields EPC.
- IDLE, ERET: EretM && ValidM && !IntPending -> same cycle InterruptRequest=1, EXLClear=1, latch target=EPCIn. Next state is REDIRECT.
- Interrupt beats ERET when both are true. In that case EPC = PC of the ERET.
- EPCOut = BranchDelayM ? PCM-4 : PCM (mod 2^32). BDOut = BranchDelayM.
  - Both are driven only while EPCWrite=1, otherwise 0.
- DRAIN: StallAll=1 every cycle, so the M instruction stays frozen. Counter increments each cycle.
  - On MDBusy==0: go to FLUSH.
  - Counter reaching DRAIN_MAX: DrainTimeout <= 1 (sticky until reset). Keep waiting.
  - IntPending deassertion in DRAIN is ignored; the interrupt is committed.
- FLUSH: one cycle, StallAll=0, InterruptRequest=1, EPCWrite=1 (EPC from the frozen PCM). Latch target=HANDLER_ADDR, clear counter. Next state is REDIRECT.
- REDIRECT: one cycle, PCRedirect=1, PCTarget=latched target, InterruptRequest=0. Next state is IDLE. New requests are not sampled in this cycle.
- Latency:
  - MDBusy low: flush at T, redirect at T+1, first handler fetch at T+2.
  - MDBusy high: flush one cycle after MDBusy falls.
- InterruptRequest and StallAll are never both 1.
- PCTarget is 0 outside REDIRECT.
- Reset mid-DRAIN/FLUSH/REDIRECT: abort immediately. No EPCWrite or redirect is emitted after release.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - FSM state constants (IDLE/DRAIN/FLUSH/REDIRECT).
  - HANDLER_ADDR default.
  - EPC delay-slot offset (4).
- Optional sub-module drain_watchdog: counter, compare against DRAIN_MAX, sticky flag; inputs clk/reset/en/clr. Everything else stays in the top module.

Test Plan:
- Plain interrupt: IntPending=1, ValidM=1, PCM=0x3010, BD=0, MDBusy=0 -> same cycle InterruptRequest=1, EPCWrite=1, EPCOut=0x3010. Next cycle PCRedirect=1, PCTarget=0x4180. Then IDLE.
- Delay slot: PCM=0x3024, BranchDelayM=1 -> EPCOut=0x3020, BDOut=1.
- Drain: MDBusy=1 for 5 cycles at detection -> StallAll=1 for 5 cycles, InterruptRequest=0 throughout. Then 1 cycle of InterruptRequest=1 and EPCWrite=1. Then redirect to 0x4180.
- ERET: EretM=1, ValidM=1, EPCIn=0x3014, IntPending=0 -> InterruptRequest=1, EXLClear=1. Next cycle PCRedirect=1, PCTarget=0x3014.
- Bubble and priority: IntPending=1 with ValidM=0 for 3 cycles -> no outputs. Then ValidM=1 with EretM=1 -> interrupt path taken, EPCOut=PCM, EXLClear=0.
- Reset/timeout: MDBusy held 70 cycles -> DrainTimeout=1 at cycle 64. Async reset pulse in DRAIN -> all outputs 0 immediately, state IDLE, DrainTimeout cleared.
